// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed layer of leaky integrate-and-fire neurons.
// One neuron is updated per clock; a step keeps the block busy N_NEURONS+1 cycles.
module lif_neuron_array #(
    parameter int N_NEURONS = 8,
    parameter int N_INPUTS = 8,
    parameter int EXT_W = 32,
    parameter int DATA_W = 32,
    parameter int REFRAC_STEPS = 2,
    parameter logic [DATA_W-1:0] W_INIT = 'h2000,
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [N_INPUTS-1:0]  spike_in,
    input  logic [EXT_W-1:0]     ext_bits,
    input  logic [DATA_W-1:0]    vth,
    input  logic [DATA_W-1:0]    leak,
    input  logic [DATA_W-1:0]    ext_w,
    input  logic                 w_we,
    input  logic [NW-1:0]        w_neuron,
    input  logic [IW-1:0]        w_input,
    input  logic [DATA_W-1:0]    w_data,
    output logic                 w_err,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 spike_valid,
    input  logic [NW-1:0]        vmem_sel,
    output logic [DATA_W-1:0]    vmem_out
);
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam int AW = DATA_W + $clog2(N_INPUTS + 1) + $clog2(EXT_W + 1) + 2;
    localparam int VW = DATA_W + 2;
    localparam logic [NW-1:0] LAST = NW'(N_NEURONS - 1);
    localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t state_q, state_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [N_INPUTS-1:0] spk_q, spk_d;
    logic [EXT_W-1:0] ext_q, ext_d;
    logic signed [DATA_W-1:0] vth_q, vth_d, leak_q, leak_d, extw_q, extw_d;
    logic signed [DATA_W-1:0] v_q [N_NEURONS];
    logic signed [DATA_W-1:0] v_d [N_NEURONS];
    logic [RW-1:0] rf_q [N_NEURONS];
    logic [RW-1:0] rf_d [N_NEURONS];
    logic signed [DATA_W-1:0] w_q [N_NEURONS][N_INPUTS];
    logic signed [DATA_W-1:0] w_d [N_NEURONS][N_INPUTS];
    logic [N_NEURONS-1:0] acc_q, acc_d, so_q, so_d;
    logic werr_q, werr_d;
    logic [DATA_W-1:0] vm_q, vm_d;

    logic accept;
    logic signed [AW-1:0] a_wide, pop;
    logic signed [DATA_W-1:0] a_sat, v_cur, vn;
    logic signed [VW-1:0] v_sum;
    logic [RW-1:0] rf_cur;
    logic fire;

    function automatic logic signed [AW-1:0] ext_a(input logic signed [DATA_W-1:0] x);
        return {{(AW-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [VW-1:0] ext_v(input logic signed [DATA_W-1:0] x);
        return {{(VW-DATA_W){x[DATA_W-1]}}, x};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: if (step_valid) begin
                state_d = S_ACCUM;
                idx_d   = '0;
            end
            S_ACCUM: if (idx_q == LAST) state_d = S_DONE;
                     else idx_d = idx_q + NW'(1);
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_ready  = 1'b0;
        spike_valid = 1'b0;
        unique case (state_q)
            S_IDLE: step_ready = 1'b1;
            S_DONE: spike_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = (state_q == S_IDLE) && step_valid;

    // Wide sum cannot overflow; saturation happens once on the total.
    always_comb begin
        v_cur  = v_q[idx_q];
        rf_cur = rf_q[idx_q];
        a_wide = '0;
        pop    = '0;
        for (int j = 0; j < N_INPUTS; j++)
            if (spk_q[j]) a_wide = a_wide + ext_a(w_q[idx_q][j]);
        for (int b = 0; b < EXT_W; b++) pop = pop + AW'(ext_q[b]);
        a_wide = a_wide + pop * ext_a(extw_q);
        if (a_wide > ext_a(D_MAX)) a_sat = D_MAX;
        else if (a_wide < ext_a(D_MIN)) a_sat = D_MIN;
        else a_sat = a_wide[DATA_W-1:0];
        if (!a_sat[DATA_W-1] && (a_sat != '0)) v_sum = ext_v(v_cur) + ext_v(a_sat);
        else v_sum = ext_v(v_cur) + ext_v(a_sat) - ext_v(leak_q);
        if (v_sum > ext_v(D_MAX)) vn = D_MAX;
        else if (v_sum[VW-1]) vn = '0;
        else vn = v_sum[DATA_W-1:0];
        fire = (rf_cur == '0) && (vn >= vth_q);
    end

    always_comb begin
        v_d    = v_q;
        rf_d   = rf_q;
        w_d    = w_q;
        acc_d  = acc_q;
        so_d   = so_q;
        spk_d  = spk_q;
        ext_d  = ext_q;
        vth_d  = vth_q;
        leak_d = leak_q;
        extw_d = extw_q;
        werr_d = 1'b0;
        if (accept) begin
            spk_d  = spike_in;
            ext_d  = ext_bits;
            vth_d  = vth;
            leak_d = leak;
            extw_d = ext_w;
            acc_d  = '0;
        end
        if (w_we) begin
            if ((state_q == S_IDLE) && (int'(w_neuron) < N_NEURONS) &&
                (int'(w_input) < N_INPUTS))
                w_d[w_neuron][w_input] = w_data;
            else
                werr_d = 1'b1;
        end
        if (state_q == S_ACCUM) begin
            if (rf_cur != '0) begin
                rf_d[idx_q] = rf_cur - RW'(1);
                v_d[idx_q]  = '0;
            end else if (fire) begin
                rf_d[idx_q]  = RW'(REFRAC_STEPS);
                v_d[idx_q]   = '0;
                acc_d[idx_q] = 1'b1;
            end else begin
                v_d[idx_q] = vn;
            end
            if (idx_q == LAST) so_d = acc_d;
        end
        vm_d = (int'(vmem_sel) < N_NEURONS) ? v_q[vmem_sel] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_q[n]  <= '0;
                rf_q[n] <= '0;
                for (int i = 0; i < N_INPUTS; i++) w_q[n][i] <= W_INIT;
            end
            spk_q  <= '0;
            ext_q  <= '0;
            vth_q  <= '0;
            leak_q <= '0;
            extw_q <= '0;
            acc_q  <= '0;
            so_q   <= '0;
            werr_q <= 1'b0;
            vm_q   <= '0;
        end else begin
            v_q    <= v_d;
            rf_q   <= rf_d;
            w_q    <= w_d;
            spk_q  <= spk_d;
            ext_q  <= ext_d;
            vth_q  <= vth_d;
            leak_q <= leak_d;
            extw_q <= extw_d;
            acc_q  <= acc_d;
            so_q   <= so_d;
            werr_q <= werr_d;
            vm_q   <= vm_d;
        end
    end

    assign spike_out = so_q;
    assign w_err     = werr_q;
    assign vmem_out  = vm_q;
endmodule
